lvds_align_ctrl: RTL and testbench

LVDS_ALIGN_CTRL -- requirements
Module: lvds_align_ctrl

---
 rtl/lvds_align_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lvds_align_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_align_ctrl.sv
// Word-alignment controller for two 4-channel LVDS links: bitslips each link until its clock lane matches CLK_PATTERN.
// Optional macro LVDS_ALIGN_AUTO_RELOCK_EN: loss of lock re-enters slipping instead of failing.
module lvds_align_ctrl #(
  parameter logic [6:0] CLK_PATTERN = 7'b1100011,
  parameter int         CLK_LANE0   = 3,
  parameter int         CLK_LANE1   = 7,
  parameter int         SETTLE_CYC  = 4,
  parameter int         LOCK_CNT    = 16,
  parameter int         LOSS_CNT    = 4
) (
  input  logic        rx_outclock,
  input  logic        rst,
  input  logic        rx_locked,
  input  logic [55:0] rx_out,
  input  logic        align_start,
  output logic [7:0]  rx_channel_data_align,
  output logic [1:0]  link_aligned,
  output logic [1:0]  align_err,
  output logic        align_done,
  output logic [2:0]  slip_cnt0,
  output logic [2:0]  slip_cnt1
);

  typedef enum logic [2:0] {
    WAIT_PLL,
    CHECK,
    SLIP,
    SETTLE,
    LOCKED,
    FAIL
  } state_t;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0] LOSS_LAST   = 8'(LOSS_CNT - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  logic unused_lanes;
  assign unused_lanes = ^rx_out;

  for (genvar l = 0; l < 2; l++) begin : g_link
    localparam int LANE = (l == 0) ? CLK_LANE0 : CLK_LANE1;

    logic [6:0] word;
    logic       match;
    state_t     state;
    logic [7:0] match_cnt;
    logic [7:0] loss_cnt;
    logic [3:0] settle_cnt;
    logic [2:0] slip_cnt;
    logic       align;
    logic       aligned;
    logic       err;

    assign word  = rx_out[7*LANE +: 7];
    assign match = (word == CLK_PATTERN);

    // PLL loss outranks a restart request, which outranks normal sequencing.
    // The align pulse is only raised on entry to SLIP, so it can never last two cycles.
    always_ff @(posedge rx_outclock or posedge rst) begin
      if (rst) begin
        state      <= WAIT_PLL;
        match_cnt  <= '0;
        loss_cnt   <= '0;
        settle_cnt <= '0;
        slip_cnt   <= '0;
        align      <= 1'b0;
        aligned    <= 1'b0;
        err        <= 1'b0;
      end else if (!rx_locked) begin
        state      <= WAIT_PLL;
        match_cnt  <= '0;
        loss_cnt   <= '0;
        settle_cnt <= '0;
        slip_cnt   <= '0;
        align      <= 1'b0;
        aligned    <= 1'b0;
        err        <= 1'b0;
      end else if (align_start) begin
        state      <= CHECK;
        match_cnt  <= '0;
        loss_cnt   <= '0;
        settle_cnt <= '0;
        slip_cnt   <= '0;
        align      <= 1'b0;
        aligned    <= 1'b0;
        err        <= 1'b0;
      end else begin
        align <= 1'b0;
        case (state)
          WAIT_PLL: begin
            state     <= CHECK;
            match_cnt <= '0;
            slip_cnt  <= '0;
          end
          CHECK: begin
            if (match) begin
              if (match_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                aligned  <= 1'b1;
                loss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
              if (slip_cnt != 3'd7) begin
                state <= SLIP;
                align <= 1'b1;
              end else begin
                state <= FAIL;
                err   <= 1'b1;
              end
            end
          end
          SLIP: begin
            if (slip_cnt != 3'd7) slip_cnt <= slip_cnt + 3'd1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state     <= CHECK;
              match_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          LOCKED: begin
            if (match) begin
              loss_cnt <= '0;
            end else if (loss_cnt == LOSS_LAST) begin
              aligned  <= 1'b0;
              loss_cnt <= '0;
`ifdef LVDS_ALIGN_AUTO_RELOCK_EN
              slip_cnt <= '0;
              state    <= SLIP;
              align    <= 1'b1;
`else
              state    <= FAIL;
              err      <= 1'b1;
`endif
            end else begin
              loss_cnt <= loss_cnt + 8'd1;
            end
          end
          FAIL: begin
            state <= FAIL;
          end
          default: state <= WAIT_PLL;
        endcase
      end
    end

    assign rx_channel_data_align[4*l +: 4] = {4{align}};
    assign link_aligned[l] = aligned;
    assign align_err[l]    = err;

    if (l == 0) begin : g_slip0
      assign slip_cnt0 = slip_cnt;
    end else begin : g_slip1
      assign slip_cnt1 = slip_cnt;
    end
  end

  always_ff @(posedge rx_outclock or posedge rst) begin
    if (rst) align_done <= 1'b0;
    else     align_done <= link_aligned[0] & link_aligned[1];
  end

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Directed bench for lvds_align_ctrl with a small bitslip model of the deserializer clock lanes.
// Expectations for loss-of-lock follow LVDS_ALIGN_AUTO_RELOCK_EN when it is defined.
module tb_lvds_align_ctrl;

  localparam logic [6:0] PAT = 7'b1100011;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_locked;
  logic [55:0] rx_out;
  logic        align_start;
  logic [7:0]  rx_channel_data_align;
  logic [1:0]  link_aligned;
  logic [1:0]  align_err;
  logic        align_done;
  logic [2:0]  slip_cnt0;
  logic [2:0]  slip_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rot0 = 0, rot1 = 0;
  bit bad0 = 0, bad1 = 0;
  int pulses0 = 0, pulses1 = 0;
  int last0 = 0, last1 = 0;

  lvds_align_ctrl dut (
    .rx_outclock          (clk),
    .rst                  (rst),
    .rx_locked            (rx_locked),
    .rx_out               (rx_out),
    .align_start          (align_start),
    .rx_channel_data_align(rx_channel_data_align),
    .link_aligned         (link_aligned),
    .align_err            (align_err),
    .align_done           (align_done),
    .slip_cnt0            (slip_cnt0),
    .slip_cnt1            (slip_cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
    logic [6:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveLanes();
    logic [6:0] filler;
    filler = 7'h2A;
    rx_out = {8{filler}};
    rx_out[21 +: 7] = bad0 ? 7'h00 : rotl(PAT, rot0);
    rx_out[49 +: 7] = bad1 ? 7'h7F : rotl(PAT, rot1);
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic s);
    rst = r;
    rx_locked = l;
    align_start = s;
    driveLanes();
  endtask

  // One clock: sample just after the edge, let the lane model react to any bitslip pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_channel_data_align[3:0] != 4'h0) begin
      checkOutput("pulse_bits0", 32'(rx_channel_data_align[3:0]), 32'hF);
      if (pulses0 > 0) checkOutput("pulse_gap0", (cyc - last0 >= SETTLE + 1) ? 32'd1 : 32'd0, 32'd1);
      pulses0++;
      last0 = cyc;
      rot0 = (rot0 + 6) % 7;
    end
    if (rx_channel_data_align[7:4] != 4'h0) begin
      checkOutput("pulse_bits1", 32'(rx_channel_data_align[7:4]), 32'hF);
      if (pulses1 > 0) checkOutput("pulse_gap1", (cyc - last1 >= SETTLE + 1) ? 32'd1 : 32'd0, 32'd1);
      pulses1++;
      last1 = cyc;
      rot1 = (rot1 + 6) % 7;
    end
    driveLanes();
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rst_align", 32'(rx_channel_data_align), 32'h0);
    checkOutput("rst_aligned", 32'(link_aligned), 32'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("waitpll_aligned", 32'(link_aligned), 32'h0);
    checkOutput("waitpll_err", 32'(align_err), 32'h0);
    checkOutput("waitpll_done", 32'(align_done), 32'h0);

    // Already aligned lanes: lock after 16 matches, no slips
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (16) tick();
    checkOutput("t1_not_yet", 32'(link_aligned), 32'h0);
    tick();
    checkOutput("t1_aligned", 32'(link_aligned), 32'h3);
    checkOutput("t1_done_lag", 32'(align_done), 32'h0);
    tick();
    checkOutput("t1_done", 32'(align_done), 32'h1);
    checkOutput("t1_pulses", 32'(pulses0 + pulses1), 32'h0);
    checkOutput("t1_slip0", 32'(slip_cnt0), 32'h0);

    // Link 0 rotated by 3: three slips then lock
    rot0 = 3;
    pulses0 = 0;
    pulses1 = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (33) tick();
    checkOutput("t2_link0_pending", 32'(link_aligned), 32'h2);
    tick();
    checkOutput("t2_aligned", 32'(link_aligned), 32'h3);
    checkOutput("t2_done_lag", 32'(align_done), 32'h0);
    tick();
    checkOutput("t2_done", 32'(align_done), 32'h1);
    checkOutput("t2_pulses0", 32'(pulses0), 32'd3);
    checkOutput("t2_pulses1", 32'(pulses1), 32'd0);
    checkOutput("t2_slip0", 32'(slip_cnt0), 32'd3);
    checkOutput("t2_slip1", 32'(slip_cnt1), 32'd0);

    // Link 0 never matches: seven slips then FAIL
    bad0 = 1;
    pulses0 = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (42) tick();
    checkOutput("t3_err_pending", 32'(align_err), 32'h0);
    tick();
    checkOutput("t3_err", 32'(align_err), 32'h1);
    checkOutput("t3_aligned", 32'(link_aligned), 32'h2);
    checkOutput("t3_pulses0", 32'(pulses0), 32'd7);
    checkOutput("t3_slip0", 32'(slip_cnt0), 32'd7);
    repeat (20) tick();
    checkOutput("t3_no_more_pulses", 32'(pulses0), 32'd7);
    checkOutput("t3_err_hold", 32'(align_err), 32'h1);

    // align_start out of FAIL, then loss of lock on link 1
    bad0 = 0;
    rot0 = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_err_cleared", 32'(align_err), 32'h0);
    repeat (16) tick();
    checkOutput("t4_aligned", 32'(link_aligned), 32'h3);
    pulses1 = 0;
    bad1 = 1;
    driveLanes();
    repeat (3) tick();
    checkOutput("t4_loss_pending", 32'(link_aligned), 32'h3);
    tick();
    bad1 = 0;
    driveLanes();
`ifdef LVDS_ALIGN_AUTO_RELOCK_EN
    checkOutput("t4_err_auto", 32'(align_err), 32'h0);
    checkOutput("t4_aligned_lost", 32'(link_aligned), 32'h1);
    checkOutput("t4_relock_pulse", 32'(pulses1), 32'd1);
    checkOutput("t4_slip1_cleared", 32'(slip_cnt1), 32'd0);
    tick();
    checkOutput("t4_slip1_first", 32'(slip_cnt1), 32'd1);
    for (int i = 0; i < 200 && link_aligned[1] !== 1'b1; i++) tick();
    checkOutput("t4_relocked", 32'(link_aligned), 32'h3);
    checkOutput("t4_relock_err", 32'(align_err), 32'h0);
    checkOutput("t4_relock_pulses", 32'(pulses1), 32'd7);
    checkOutput("t4_relock_slip1", 32'(slip_cnt1), 32'd7);
`else
    checkOutput("t4_err_fail", 32'(align_err), 32'h2);
    checkOutput("t4_aligned_lost", 32'(link_aligned), 32'h1);
    tick();
    checkOutput("t4_done_drop", 32'(align_done), 32'h0);
    repeat (10) tick();
    checkOutput("t4_no_pulses", 32'(pulses1), 32'd0);
    checkOutput("t4_err_hold", 32'(align_err), 32'h2);
`endif

    // align_start clears err next cycle; rx_locked drop mid-SETTLE returns to idle
`ifdef LVDS_ALIGN_AUTO_RELOCK_EN
    checkOutput("t5_err_before", 32'(align_err), 32'h0);
`else
    checkOutput("t5_err_before", 32'(align_err), 32'h2);
`endif
    rot0 = 3;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_err_cleared", 32'(align_err), 32'h0);
    checkOutput("t5_check_aligned", 32'(link_aligned), 32'h0);
    tick();
    checkOutput("t5_pulse", 32'(rx_channel_data_align), 32'h0F);
    tick();
    checkOutput("t5_pulse_single", 32'(rx_channel_data_align), 32'h00);
    checkOutput("t5_slip0", 32'(slip_cnt0), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t5_pll_align", 32'(rx_channel_data_align), 32'h0);
    checkOutput("t5_pll_aligned", 32'(link_aligned), 32'h0);
    checkOutput("t5_pll_err", 32'(align_err), 32'h0);
    checkOutput("t5_pll_done", 32'(align_done), 32'h0);
    checkOutput("t5_pll_slips", 32'({slip_cnt1, slip_cnt0}), 32'h0);

    // Relock after PLL returns, then asynchronous reset between edges
    rot0 = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (17) tick();
    checkOutput("t6_relock", 32'(link_aligned), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("t6_async_aligned", 32'(link_aligned), 32'h0);
    checkOutput("t6_async_done", 32'(align_done), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
